// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and burst address arithmetic used by the crossbar,
// the DMA engine and the voxel BRAM responder.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Address of the next beat; callers zero-extend into and truncate out of 64 bits.
    function automatic logic [63:0] axi_burst_next_addr(
        input logic [63:0] addr,
        input logic [2:0]  size,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [63:0] incr;
        logic [63:0] wrap_mask;
        logic [63:0] nxt;
        incr      = 64'd1 << size;
        wrap_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        case (burst)
            AXI_BURST_FIXED: nxt = addr;
            AXI_BURST_INCR:  nxt = addr + incr;
            AXI_BURST_WRAP:  nxt = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
            default:         nxt = addr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/voxel_bram_sp.sv
// Single-port BRAM: synchronous read (old data on a same-address write),
// per-byte write enables. Contents are never reset.
module voxel_bram_sp #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_BITS  = 9
) (
    input  logic                      clk,
    input  logic [ADDR_BITS-1:0]      i_addr,
    input  logic [DATA_WIDTH/8-1:0]   i_we,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic [DATA_WIDTH-1:0]     o_rdata
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_BITS];

    // Byte-masked write and registered read of the same word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/axi_voxel_bram_slave.sv
// AXI4 responder for the voxel window: one transaction at a time, reads and
// writes arbitrated round-robin, backed by a synchronous-read BRAM.
module axi_voxel_bram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_WORDS_LOG2 = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int         NBYTES   = DATA_WIDTH / 8;
    localparam int         WORD_LSB = $clog2(NBYTES);
    localparam int         IDX_MSB  = MEM_WORDS_LOG2 + WORD_LSB - 1;
    localparam logic [2:0] SIZE_MAX = 3'(WORD_LSB);

    typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_WRESP, ST_RDATA} slv_state_e;

    slv_state_e              r_state;
    slv_state_e              w_state_nxt;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [7:0]              r_beat;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic                    r_err;
    logic                    r_err_last;
    logic                    r_wr_prio;

    logic                    w_beat_last;
    logic [63:0]             w_next_full;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [ADDR_WIDTH-1:0]   w_mem_baddr;
    logic [NBYTES-1:0]       w_mem_we;
    logic [DATA_WIDTH-1:0]   w_mem_q;
    logic                    w_unused;

    function automatic logic txn_err(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == AXI_BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        return (size > SIZE_MAX) || (burst == 2'b11) || bad_wrap;
    endfunction

    assign w_beat_last = (r_beat == r_len);
    assign w_next_full = axi_burst_next_addr(64'(r_addr), r_size, r_len, r_burst);
    assign w_next_addr = w_next_full[ADDR_WIDTH-1:0];
    assign w_unused    = ^{w_next_full[63:ADDR_WIDTH], w_mem_baddr[ADDR_WIDTH-1:IDX_MSB+1],
                           w_mem_baddr[WORD_LSB-1:0]};

    // Next state, handshake readies and BRAM port control.
    always_comb begin
        w_state_nxt = r_state;
        awready     = 1'b0;
        arready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        rvalid      = 1'b0;
        w_mem_baddr = r_addr;
        w_mem_we    = '0;
        case (r_state)
            ST_IDLE: begin
                awready     = rst_n && awvalid && (!arvalid || r_wr_prio);
                arready     = rst_n && arvalid && (!awvalid || !r_wr_prio);
                // Pre-address the BRAM so the first read beat is ready one cycle after AR.
                w_mem_baddr = araddr;
                if (awready) begin
                    w_state_nxt = ST_WDATA;
                end else if (arready) begin
                    w_state_nxt = ST_RDATA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WDATA: begin
                wready   = 1'b1;
                w_mem_we = (wvalid && !r_err) ? wstrb : '0;
                if (wvalid && w_beat_last) begin
                    w_state_nxt = ST_WRESP;
                end else begin
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_WRESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_RDATA: begin
                rvalid = 1'b1;
                // Re-read the current word while stalled so rdata stays put.
                if (rready) begin
                    w_mem_baddr = w_next_addr;
                end else begin
                    w_mem_baddr = r_addr;
                end
                if (rready && w_beat_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, latched transaction attributes and beat tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= 8'd0;
            r_beat     <= 8'd0;
            r_size     <= 3'd0;
            r_burst    <= 2'b00;
            r_err      <= 1'b0;
            r_err_last <= 1'b0;
            r_wr_prio  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (awready) begin
                        r_id       <= awid;
                        r_addr     <= awaddr;
                        r_len      <= awlen;
                        r_size     <= awsize;
                        r_burst    <= awburst;
                        r_beat     <= 8'd0;
                        r_err      <= txn_err(awsize, awlen, awburst);
                        r_err_last <= 1'b0;
                        r_wr_prio  <= 1'b0;
                    end else if (arready) begin
                        r_id       <= arid;
                        r_addr     <= araddr;
                        r_len      <= arlen;
                        r_size     <= arsize;
                        r_burst    <= arburst;
                        r_beat     <= 8'd0;
                        r_err      <= txn_err(arsize, arlen, arburst);
                        r_err_last <= 1'b0;
                        r_wr_prio  <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (wvalid) begin
                        r_addr <= w_next_addr;
                        r_beat <= r_beat + 8'd1;
                        if (wlast != w_beat_last) begin
                            r_err_last <= 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (rready) begin
                        r_addr <= w_next_addr;
                        r_beat <= r_beat + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bid   = r_id;
    assign rid   = r_id;
    assign bresp = (r_err || r_err_last) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign rresp = r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign rlast = (r_state == ST_RDATA) && w_beat_last;
    assign rdata = ((r_state == ST_RDATA) && !r_err) ? w_mem_q : '0;

    voxel_bram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_WORDS_LOG2)
    ) u_bram (
        .clk     (clk),
        .i_addr  (w_mem_baddr[IDX_MSB:WORD_LSB]),
        .i_we    (w_mem_we),
        .i_wdata (wdata),
        .o_rdata (w_mem_q)
    );

endmodule

// File: tb/tb_axi_voxel_bram_slave.sv
// Scoreboard bench for axi_voxel_bram_slave: tasks push expected B/R
// responses, negedge monitors pop and compare them.
module tb_axi_voxel_bram_slave;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid, arid, bid, rid;
    logic [27:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    typedef struct packed {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_exp_t;
    typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;

    r_exp_t      exp_r[$];
    b_exp_t      exp_b[$];
    r_exp_t      mon_r;
    b_exp_t      mon_b;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          aw_cyc, ar_cyc;
    logic [63:0] wr_dat[16];
    logic [7:0]  wr_stb[16];
    logic [63:0] rd_exp[16];
    logic [3:0]  bp_pat = 4'b1001;
    logic [63:0] held_rdata;
    bit          held_v = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    axi_voxel_bram_slave dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // B channel monitor
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                timeout("b_unexpected");
            end else begin
                mon_b = exp_b.pop_front();
                chk("bid", 64'(bid), 64'(mon_b.id));
                chk("bresp", 64'(bresp), 64'(mon_b.resp));
            end
        end
    end

    // R channel monitor, including rdata stability while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v && rvalid) chk("r_stall_stable", rdata, held_rdata);
            held_v = 1'b0;
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    timeout("r_unexpected");
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("rid", 64'(rid), 64'(mon_r.id));
                    chk("rdata", rdata, mon_r.data);
                    chk("rresp", 64'(rresp), 64'(mon_r.resp));
                    chk("rlast", 64'(rlast), 64'(mon_r.last));
                end
            end else if (rvalid) begin
                held_v = 1'b1;
                held_rdata = rdata;
            end
        end
    end

    task automatic do_write(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [1:0] resp, input bit early_last);
        int n;
        exp_b.push_back('{id: id, resp: resp});
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (!awready) begin timeout("aw_handshake"); awvalid = 1'b0; return; end
        aw_cyc = cyc;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("wready_latency", 64'(wready), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wr_dat[i]; wstrb = wr_stb[i]; wvalid = 1'b1;
            wlast = early_last ? 1'b1 : (i == int'(len));
            n = 0;
            @(negedge clk);
            while (!wready && n < 100) begin @(negedge clk); n++; end
            if (!wready) begin timeout("w_handshake"); wvalid = 1'b0; return; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_latency", 64'(bvalid), 64'd1);
        n = 0;
        while (exp_b.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        if (exp_b.size() != 0) timeout("b_wait");
    endtask

    task automatic do_read(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] resp, input bit bp, input bit wait_done);
        int n;
        for (int i = 0; i <= int'(len); i++)
            exp_r.push_back('{id: id, data: rd_exp[i], resp: resp, last: (i == int'(len))});
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (!arready) begin timeout("ar_handshake"); arvalid = 1'b0; return; end
        ar_cyc = cyc;
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rvalid_latency", 64'(rvalid), 64'd1);
        if (wait_done) begin
            n = 0;
            while (exp_r.size() != 0 && n < 200) begin
                rready = bp ? bp_pat[n % 4] : 1'b1;
                @(posedge clk); #1;
                n++;
            end
            rready = 1'b1;
            if (exp_r.size() != 0) timeout("r_wait");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        awvalid = 1'b1; arvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_valids", 64'({wready, bvalid, rvalid, rlast}), 64'd0);
        chk("rst_ids_resps", 64'({bid, rid, bresp, rresp}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        awvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single beat write then read
        wr_dat[0] = 64'hDEADBEEF_CAFEF00D; wr_stb[0] = 8'hFF;
        do_write(4'h3, 28'h010, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        rd_exp[0] = 64'hDEADBEEF_CAFEF00D;
        do_read(4'h3, 28'h010, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0, 1'b1);

        // INCR burst, read back under backpressure 1,0,0,1
        for (int i = 0; i < 8; i++) begin
            wr_dat[i] = 64'(i + 1); wr_stb[i] = 8'hFF; rd_exp[i] = 64'(i + 1);
        end
        do_write(4'h1, 28'h100, 8'd7, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        do_read(4'h2, 28'h100, 8'd7, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b1, 1'b1);

        // WRAP: 8-byte slots 0x40.. hold 0..7, read 4 beats from 0x50
        for (int i = 0; i < 8; i++) wr_dat[i] = 64'(i);
        do_write(4'h4, 28'h040, 8'd7, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        rd_exp[0] = 64'd2; rd_exp[1] = 64'd3; rd_exp[2] = 64'd0; rd_exp[3] = 64'd1;
        do_read(4'h5, 28'h050, 8'd3, 3'd3, AXI_BURST_WRAP, AXI_RESP_OKAY, 1'b0, 1'b1);

        // FIXED burst with single-byte strobes
        wr_dat[0] = 64'd0; wr_stb[0] = 8'hFF;
        do_write(4'h6, 28'h200, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
        wr_dat[0] = 64'hFFFF_FFFF_FFFF_FF11; wr_stb[0] = 8'h01;
        wr_dat[1] = 64'hFFFF_FFFF_FFFF_22FF; wr_stb[1] = 8'h02;
        do_write(4'h6, 28'h200, 8'd1, 3'd3, AXI_BURST_FIXED, AXI_RESP_OKAY, 1'b0);
        rd_exp[0] = 64'h2211;
        do_read(4'h7, 28'h200, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0, 1'b1);

        // error cases
        rd_exp[0] = 64'd0; rd_exp[1] = 64'd0; rd_exp[2] = 64'd0;
        do_read(4'h8, 28'h010, 8'd1, 3'd4, AXI_BURST_INCR, AXI_RESP_SLVERR, 1'b0, 1'b1);
        do_read(4'hB, 28'h040, 8'd2, 3'd3, AXI_BURST_WRAP, AXI_RESP_SLVERR, 1'b0, 1'b1);
        wr_dat[0] = 64'hA1; wr_stb[0] = 8'hFF; wr_dat[1] = 64'hA2; wr_stb[1] = 8'hFF;
        do_write(4'h9, 28'h300, 8'd1, 3'd3, AXI_BURST_INCR, AXI_RESP_SLVERR, 1'b1);
        rd_exp[0] = 64'hA1; rd_exp[1] = 64'hA2;
        do_read(4'h9, 28'h300, 8'd1, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0, 1'b1);
        wr_dat[0] = 64'h55;
        do_write(4'hA, 28'h010, 8'd0, 3'd3, 2'b11, AXI_RESP_SLVERR, 1'b0);
        rd_exp[0] = 64'hDEADBEEF_CAFEF00D;
        do_read(4'hA, 28'h010, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0, 1'b1);

        // simultaneous AW and AR, twice
        wr_dat[0] = 64'h0123_4567_89AB_CDEF; wr_stb[0] = 8'hFF;
        rd_exp[0] = 64'hDEADBEEF_CAFEF00D;
        fork
            do_write(4'hC, 28'h400, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
            do_read(4'hD, 28'h010, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0, 1'b1);
        join
        chk("arb1_write_first", 64'(aw_cyc < ar_cyc), 64'd1);
        wr_dat[0] = 64'h1111; rd_exp[0] = 64'h0123_4567_89AB_CDEF;
        fork
            do_write(4'hC, 28'h408, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0);
            do_read(4'hD, 28'h400, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0, 1'b1);
        join
        chk("arb2_write_first", 64'(aw_cyc < ar_cyc), 64'd1);

        // reset in the middle of a read burst
        for (int i = 0; i < 8; i++) rd_exp[i] = 64'(i + 1);
        do_read(4'hE, 28'h100, 8'd7, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_r.delete();
        #1;
        chk("midrst_rvalid", 64'(rvalid), 64'd0);
        chk("midrst_rlast", 64'(rlast), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_exp[0] = 64'hDEADBEEF_CAFEF00D;
        do_read(4'hF, 28'h010, 8'd0, 3'd3, AXI_BURST_INCR, AXI_RESP_OKAY, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
